// File: rtl/countdown_ctrl.sv
// countdown_ctrl: sequencer for the minute/second countdown datapath.
// Divides clk to a 1 Hz tick, turns set/start/pause/clear commands into
// datapath load/tick strobes, and raises a timed alarm on expiry.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   cmd_set          one-cycle pulse, loads set_minute (clamped to MAX_MIN)
//   set_minute       requested minutes, sampled with cmd_set
//   cmd_start        one-cycle pulse, start (ARMED) or resume (PAUSE)
//   cmd_pause        one-cycle pulse, pause while running
//   cmd_clear        one-cycle pulse, abort and zero the datapath
//   tmr_minute       current datapath minutes
//   tmr_second       current datapath seconds
//   tmr_load         one-cycle load strobe to the datapath
//   tmr_load_minute  minute value presented with tmr_load
//   tmr_tick         one-cycle decrement enable, once per second in RUN
//   state            IDLE=0 ARMED=1 RUN=2 PAUSE=3 EXPIRED=4
//   running          high while state is RUN
//   alarm            high for ALARM_SEC seconds after expiry
module countdown_ctrl #(
    parameter int CLK_HZ    = 4000000,
    parameter int CNT_W     = 22,
    parameter int MAX_MIN   = 99,
    parameter int ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_set,
    input  logic [6:0] set_minute,
    input  logic       cmd_start,
    input  logic       cmd_pause,
    input  logic       cmd_clear,
    input  logic [6:0] tmr_minute,
    input  logic [5:0] tmr_second,
    output logic       tmr_load,
    output logic [6:0] tmr_load_minute,
    output logic       tmr_tick,
    output logic [2:0] state,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PRE_MAX    = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_SEC - 1);
    localparam logic [6:0]       MAX_M      = 7'(MAX_MIN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] acnt_q, acnt_d;
    logic             alarm_q, alarm_d;
    logic             load_q, load_d;
    logic [6:0]       load_min_q, load_min_d;
    logic             tick_q, tick_d;
    logic             running_q;

    logic             wrap;
    logic             zero;
    logic             set_ok;
    logic [6:0]       clamped;

    assign wrap    = (pre_q == PRE_MAX);
    assign zero    = (tmr_minute == 7'd0) && (tmr_second == 6'd0);
    // set is ignored (treated as absent) in RUN or with a zero request
    assign set_ok  = cmd_set && (state_q != RUN) && (set_minute != 7'd0);
    assign clamped = (set_minute > MAX_M) ? MAX_M : set_minute;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        acnt_d     = acnt_q;
        alarm_d    = alarm_q;
        load_d     = 1'b0;
        load_min_d = load_min_q;
        tick_d     = 1'b0;

        if (cmd_clear) begin
            state_d    = IDLE;
            load_d     = 1'b1;
            load_min_d = 7'd0;
            pre_d      = '0;
            alarm_d    = 1'b0;
            acnt_d     = '0;
        end else if (set_ok) begin
            state_d    = ARMED;
            load_d     = 1'b1;
            load_min_d = clamped;
            alarm_d    = 1'b0;
            acnt_d     = '0;
        end else if (cmd_pause && state_q == RUN) begin
            state_d = PAUSE;
        end else if (cmd_start && state_q == ARMED) begin
            state_d = RUN;
            pre_d   = '0;
        end else if (cmd_start && state_q == PAUSE) begin
            // prescaler kept so the fractional second survives the pause
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (zero) begin
                        state_d = EXPIRED;
                        pre_d   = '0;
                        alarm_d = 1'b1;
                        acnt_d  = '0;
                    end else if (wrap) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        pre_d = pre_q + CNT_W'(1);
                    end
                end
                EXPIRED: begin
                    if (wrap) begin
                        pre_d = '0;
                        if (alarm_q) begin
                            if (acnt_q == ALARM_LAST) begin
                                alarm_d = 1'b0;
                                acnt_d  = '0;
                            end else begin
                                acnt_d = acnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        pre_d = pre_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            acnt_q     <= '0;
            alarm_q    <= 1'b0;
            load_q     <= 1'b0;
            load_min_q <= 7'd0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            acnt_q     <= acnt_d;
            alarm_q    <= alarm_d;
            load_q     <= load_d;
            load_min_q <= load_min_d;
            tick_q     <= tick_d;
            running_q  <= (state_d == RUN);
        end
    end

    assign tmr_load        = load_q;
    assign tmr_load_minute = load_min_q;
    assign tmr_tick        = tick_q;
    assign state           = state_q;
    assign running         = running_q;
    assign alarm           = alarm_q;

endmodule
